// File: rtl/aes_key_schedule_multi.sv
// Iterative AES-128/192/256 key expansion. It produces one schedule word per clock
// and serves round keys in forward or reversed order through a registered read port.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  // Entry a sits at bit 2047-8a, which equals {~a, 3'b111}.
  assign y = SBOX[{~a, 3'b111} -: 8];
endmodule

module aes_key_schedule_multi #(
  parameter int MAX_NK = 8
) (
  input  logic         aclk,
  input  logic         areset,
  input  logic         key_init,
  input  logic [1:0]   keylen,
  input  logic [255:0] key,
  output logic         key_ready,
  output logic         busy,
  output logic [3:0]   num_rounds,
  output logic         err_keylen,
  input  logic [3:0]   rd_round,
  input  logic         rd_inv,
  output logic [127:0] rd_key,
  output logic [1:0]   dbg_state
);
  localparam int DEPTH = 4 * (MAX_NK + 7);
  localparam logic [3:0] MAX_NK_L = 4'(MAX_NK);

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;

  state_t      state;
  logic [31:0] w_mem [DEPTH];
  logic [3:0]  nk;
  logic [5:0]  idx;
  logic [5:0]  last_idx;
  logic [2:0]  imod;
  logic [7:0]  rcon;

  logic [3:0]  nk_new, nr_new;
  logic        key_legal, init_ok;
  logic [5:0]  prev_idx, back_idx;
  logic [31:0] prev_w, back_w, sub_in, sub_out, temp_w, new_word;
  logic [3:0]  rd_r;
  logic [5:0]  rd_base;
  logic        rd_hit;
  logic [127:0] rd_word;

  assign dbg_state = state;

  always_comb begin
    nk_new = 4'd0;
    nr_new = 4'd0;
    case (keylen)
      2'b00:   begin nk_new = 4'd4; nr_new = 4'd10; end
      2'b01:   begin nk_new = 4'd6; nr_new = 4'd12; end
      2'b10:   begin nk_new = 4'd8; nr_new = 4'd14; end
      default: begin nk_new = 4'd0; nr_new = 4'd0; end
    endcase
    key_legal = (keylen != 2'b11) && (nk_new <= MAX_NK_L);
    init_ok   = key_init && key_legal;
  end

  always_comb begin
    prev_idx = idx - 6'd1;
    back_idx = idx - {2'b00, nk};
    prev_w   = 32'h0;
    back_w   = 32'h0;
    if (int'(prev_idx) < DEPTH) prev_w = w_mem[prev_idx];
    if (int'(back_idx) < DEPTH) back_w = w_mem[back_idx];
    sub_in = (imod == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
  end

  for (genvar g = 0; g < 4; g++) begin : g_sub
    aes_sbox u_sbox (.a(sub_in[8*g +: 8]), .y(sub_out[8*g +: 8]));
  end

  always_comb begin
    temp_w = prev_w;
    if (imod == 3'd0)                     temp_w = sub_out ^ {rcon, 24'h0};
    else if (nk == 4'd8 && imod == 3'd4)  temp_w = sub_out;
    new_word = back_w ^ temp_w;
  end

  // Index is computed in 4 bits, so out-of-range requests are filtered by rd_hit, not by r.
  always_comb begin
    rd_r    = rd_inv ? (num_rounds - rd_round) : rd_round;
    rd_base = {rd_r, 2'b00};
    rd_hit  = key_ready && (rd_round <= num_rounds);
    rd_word = 128'h0;
    for (int k = 0; k < 4; k++) begin
      if (int'(rd_base) + k < DEPTH) rd_word[127-32*k -: 32] = w_mem[rd_base + 6'(k)];
    end
  end

  // Storage is deliberately left out of reset; key_ready masks stale contents.
  always_ff @(posedge aclk) begin
    if (init_ok) begin
      for (int j = 0; j < 8; j++) begin
        if (4'(j) < nk_new) w_mem[j] <= key[255-32*j -: 32];
      end
    end else if (state == S_EXPAND && int'(idx) < DEPTH) begin
      w_mem[idx] <= new_word;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state      <= S_IDLE;
      key_ready  <= 1'b0;
      busy       <= 1'b0;
      num_rounds <= 4'd0;
      err_keylen <= 1'b0;
      rd_key     <= 128'h0;
      nk         <= 4'd0;
      idx        <= 6'd0;
      last_idx   <= 6'd0;
      imod       <= 3'd0;
      rcon       <= 8'h00;
    end else begin
      err_keylen <= key_init && !key_legal;
      rd_key     <= rd_hit ? rd_word : 128'h0;
      if (init_ok) begin
        nk         <= nk_new;
        num_rounds <= nr_new;
        idx        <= {2'b00, nk_new};
        last_idx   <= {nr_new, 2'b11};
        imod       <= 3'd0;
        rcon       <= 8'h01;
        key_ready  <= 1'b0;
        busy       <= 1'b1;
        state      <= S_EXPAND;
      end else begin
        case (state)
          S_EXPAND: begin
            idx  <= idx + 6'd1;
            imod <= ({1'b0, imod} == nk - 4'd1) ? 3'd0 : imod + 3'd1;
            if (imod == 3'd0) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            if (idx == last_idx) begin
              key_ready <= 1'b1;
              busy      <= 1'b0;
              state     <= S_DONE;
            end
          end
          S_DONE:  state <= S_DONE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_aes_key_schedule_multi.sv
// Bench for aes_key_schedule_multi: FIPS-197 vectors for all key sizes, abort and restart,
// illegal key lengths on full and MAX_NK=4 builds, reset behaviour and same-edge reads.

module tb_aes_key_schedule_multi;
  logic         aclk = 1'b0;
  logic         areset, key_init, rd_inv, s_key_init;
  logic [1:0]   keylen, s_keylen;
  logic [255:0] key;
  logic [3:0]   rd_round;
  logic         key_ready, busy, err_keylen, s_key_ready, s_busy, s_err_keylen;
  logic [3:0]   num_rounds, s_num_rounds;
  logic [127:0] rd_key, s_rd_key;
  logic [1:0]   dbg_state, s_dbg_state;

  int checks = 0;
  int failures = 0;
  logic [127:0] exp_q[$];
  logic [127:0] exp_v;

  localparam logic [255:0] K128 = 256'h000102030405060708090a0b0c0d0e0f_deadbeefdeadbeefdeadbeefdeadbeef;
  localparam logic [255:0] K192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617_a5a5a5a5a5a5a5a5;
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] A128_R0  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] A128_R1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] A128_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] A192_R12 = 128'ha4970a331a78dc09c418c271e3a41d5d;
  localparam logic [127:0] A256_R1  = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] A256_R14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;

  aes_key_schedule_multi #(.MAX_NK(8)) u_dut (
    .aclk(aclk), .areset(areset), .key_init(key_init), .keylen(keylen), .key(key),
    .key_ready(key_ready), .busy(busy), .num_rounds(num_rounds), .err_keylen(err_keylen),
    .rd_round(rd_round), .rd_inv(rd_inv), .rd_key(rd_key), .dbg_state(dbg_state)
  );

  aes_key_schedule_multi #(.MAX_NK(4)) u_small (
    .aclk(aclk), .areset(areset), .key_init(s_key_init), .keylen(s_keylen), .key(key),
    .key_ready(s_key_ready), .busy(s_busy), .num_rounds(s_num_rounds), .err_keylen(s_err_keylen),
    .rd_round(rd_round), .rd_inv(rd_inv), .rd_key(s_rd_key), .dbg_state(s_dbg_state)
  );

  // clock / reset
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic load_key(input logic [1:0] kl, input logic [255:0] k);
    keylen = kl;
    key = k;
    key_init = 1'b1;
    tick();
    key_init = 1'b0;
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!key_ready && cnt < 200) begin
      tick();
      cnt++;
    end
  endtask

  task automatic drive_read(input logic [3:0] r, input logic inv, input logic [127:0] e);
    rd_round = r;
    rd_inv = inv;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    areset = 1'b1; key_init = 1'b0; s_key_init = 1'b0;
    keylen = 2'b00; s_keylen = 2'b00; key = '0; rd_round = 4'd0; rd_inv = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    checks++;
    if ({key_ready, busy, num_rounds, err_keylen, dbg_state} !== 9'd0)
      $display("FAIL reset_ctrl got=%b exp=0", {key_ready, busy, num_rounds, err_keylen, dbg_state});
    checks++;
    if (rd_key !== 128'h0) $display("FAIL reset_rd_key got=%h exp=0", rd_key);
    if (rd_key !== 128'h0 || {key_ready, busy, num_rounds, err_keylen, dbg_state} !== 9'd0)
      failures++;
    areset = 1'b0;
    tick();
  endtask

  task automatic test_aes128();
    int cnt;
    logic [3:0]   rr [6] = '{4'd0, 4'd1, 4'd10, 4'd10, 4'd0, 4'd11};
    logic         ri [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [127:0] re [6] = '{A128_R0, A128_R1, A128_R10, A128_R0, A128_R10, 128'h0};
    load_key(2'b00, K128);
    checks++;
    if (busy !== 1'b1 || key_ready !== 1'b0) begin
      failures++; $display("FAIL a128_busy got=%b%b exp=10", busy, key_ready);
    end
    wait_ready(cnt);
    checks++;
    if (cnt !== 40) begin failures++; $display("FAIL a128_latency got=%0d exp=40", cnt); end
    checks++;
    if (num_rounds !== 4'd10 || busy !== 1'b0) begin
      failures++; $display("FAIL a128_nr got=%0d busy=%b exp=10 busy=0", num_rounds, busy);
    end
    for (int n = 0; n < 6; n++) begin
      drive_read(rr[n], ri[n], re[n]);
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (rd_key !== exp_v) begin
        failures++; $display("FAIL a128_read[%0d] got=%h exp=%h", n, rd_key, exp_v);
      end
    end
  endtask

  task automatic test_aes192();
    int cnt;
    logic [3:0]   rr [4] = '{4'd12, 4'd13, 4'd0, 4'd0};
    logic         ri [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [127:0] re [4] = '{A192_R12, 128'h0, A128_R0, A192_R12};
    load_key(2'b01, K192);
    wait_ready(cnt);
    checks++;
    if (cnt !== 46) begin failures++; $display("FAIL a192_latency got=%0d exp=46", cnt); end
    checks++;
    if (num_rounds !== 4'd12) begin failures++; $display("FAIL a192_nr got=%0d exp=12", num_rounds); end
    for (int n = 0; n < 4; n++) begin
      drive_read(rr[n], ri[n], re[n]);
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (rd_key !== exp_v) begin
        failures++; $display("FAIL a192_read[%0d] got=%h exp=%h", n, rd_key, exp_v);
      end
    end
  endtask

  task automatic test_aes256();
    int cnt;
    logic [3:0]   rr [5] = '{4'd1, 4'd14, 4'd0, 4'd0, 4'd15};
    logic         ri [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [127:0] re [5] = '{A256_R1, A256_R14, A256_R14, A128_R0, 128'h0};
    load_key(2'b10, K256);
    wait_ready(cnt);
    checks++;
    if (cnt !== 52) begin failures++; $display("FAIL a256_latency got=%0d exp=52", cnt); end
    checks++;
    if (num_rounds !== 4'd14) begin failures++; $display("FAIL a256_nr got=%0d exp=14", num_rounds); end
    for (int n = 0; n < 5; n++) begin
      drive_read(rr[n], ri[n], re[n]);
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (rd_key !== exp_v) begin
        failures++; $display("FAIL a256_read[%0d] got=%h exp=%h", n, rd_key, exp_v);
      end
    end
  endtask

  task automatic test_abort();
    int cnt;
    load_key(2'b10, K256);
    repeat (19) tick();
    checks++;
    if (busy !== 1'b1 || key_ready !== 1'b0) begin
      failures++; $display("FAIL abort_mid got=%b%b exp=10", busy, key_ready);
    end
    load_key(2'b00, K128);
    wait_ready(cnt);
    checks++;
    if (cnt !== 40) begin failures++; $display("FAIL abort_latency got=%0d exp=40", cnt); end
    drive_read(4'd1, 1'b0, A128_R1);
    tick();
    exp_v = exp_q.pop_front();
    checks++;
    if (rd_key !== exp_v) begin failures++; $display("FAIL abort_r1 got=%h exp=%h", rd_key, exp_v); end
    drive_read(4'd10, 1'b0, A128_R10);
    tick();
    exp_v = exp_q.pop_front();
    checks++;
    if (rd_key !== exp_v) begin failures++; $display("FAIL abort_r10 got=%h exp=%h", rd_key, exp_v); end
  endtask

  task automatic test_illegal();
    drive_read(4'd1, 1'b0, A128_R1);
    keylen = 2'b11;
    key = K256;
    key_init = 1'b1;
    tick();
    key_init = 1'b0;
    exp_v = exp_q.pop_front();
    checks++;
    if (err_keylen !== 1'b1 || key_ready !== 1'b1 || num_rounds !== 4'd10 || busy !== 1'b0) begin
      failures++;
      $display("FAIL illegal_pulse got err=%b rdy=%b nr=%0d busy=%b exp err=1 rdy=1 nr=10 busy=0",
               err_keylen, key_ready, num_rounds, busy);
    end
    checks++;
    if (rd_key !== exp_v) begin failures++; $display("FAIL illegal_read0 got=%h exp=%h", rd_key, exp_v); end
    drive_read(4'd1, 1'b0, A128_R1);
    tick();
    exp_v = exp_q.pop_front();
    checks++;
    if (err_keylen !== 1'b0 || key_ready !== 1'b1) begin
      failures++; $display("FAIL illegal_one_cycle got err=%b rdy=%b exp err=0 rdy=1", err_keylen, key_ready);
    end
    checks++;
    if (rd_key !== exp_v) begin failures++; $display("FAIL illegal_read1 got=%h exp=%h", rd_key, exp_v); end
  endtask

  task automatic test_small();
    int cnt;
    s_keylen = 2'b10;
    key = K256;
    s_key_init = 1'b1;
    tick();
    s_key_init = 1'b0;
    checks++;
    if (s_err_keylen !== 1'b1 || s_key_ready !== 1'b0 || s_num_rounds !== 4'd0 || s_busy !== 1'b0) begin
      failures++;
      $display("FAIL small_reject got err=%b rdy=%b nr=%0d busy=%b exp 1 0 0 0",
               s_err_keylen, s_key_ready, s_num_rounds, s_busy);
    end
    tick();
    checks++;
    if (s_err_keylen !== 1'b0) begin failures++; $display("FAIL small_err_len got=%b exp=0", s_err_keylen); end
    s_keylen = 2'b00;
    key = K128;
    s_key_init = 1'b1;
    tick();
    s_key_init = 1'b0;
    cnt = 0;
    while (!s_key_ready && cnt < 200) begin tick(); cnt++; end
    checks++;
    if (cnt !== 40) begin failures++; $display("FAIL small_latency got=%0d exp=40", cnt); end
    s_keylen = 2'b10;
    key = K256;
    s_key_init = 1'b1;
    drive_read(4'd10, 1'b0, A128_R10);
    tick();
    s_key_init = 1'b0;
    drive_read(4'd10, 1'b0, A128_R10);
    tick();
    checks++;
    if (s_key_ready !== 1'b1 || s_num_rounds !== 4'd10 || s_err_keylen !== 1'b0) begin
      failures++; $display("FAIL small_keep got rdy=%b nr=%0d exp rdy=1 nr=10", s_key_ready, s_num_rounds);
    end
    for (int n = 0; n < 2; n++) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (s_rd_key !== exp_v) begin
        failures++; $display("FAIL small_read[%0d] got=%h exp=%h", n, s_rd_key, exp_v);
      end
    end
  endtask

  task automatic test_same_edge();
    int cnt;
    drive_read(4'd10, 1'b0, A128_R10);
    keylen = 2'b10;
    key = K256;
    key_init = 1'b1;
    tick();
    key_init = 1'b0;
    exp_v = exp_q.pop_front();
    checks++;
    if (rd_key !== exp_v) begin failures++; $display("FAIL same_edge_old got=%h exp=%h", rd_key, exp_v); end
    checks++;
    if (key_ready !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL same_edge_ready got rdy=%b busy=%b exp 0 1", key_ready, busy);
    end
    drive_read(4'd10, 1'b0, 128'h0);
    tick();
    exp_v = exp_q.pop_front();
    checks++;
    if (rd_key !== exp_v) begin failures++; $display("FAIL same_edge_masked got=%h exp=%h", rd_key, exp_v); end
    wait_ready(cnt);
    checks++;
    if (cnt + 1 !== 52) begin failures++; $display("FAIL same_edge_latency got=%0d exp=52", cnt + 1); end
  endtask

  task automatic test_reset_mid();
    drive_read(4'd14, 1'b0, A256_R14);
    tick();
    exp_v = exp_q.pop_front();
    checks++;
    if (rd_key !== exp_v) begin failures++; $display("FAIL pre_reset_read got=%h exp=%h", rd_key, exp_v); end
    #2 areset = 1'b1;
    #1;
    checks++;
    if (rd_key !== 128'h0 || {key_ready, busy, num_rounds, err_keylen, dbg_state} !== 9'd0) begin
      failures++; $display("FAIL reset_done got rd=%h rdy=%b nr=%0d exp 0", rd_key, key_ready, num_rounds);
    end
    #1 areset = 1'b0;
    tick();
    load_key(2'b01, K192);
    repeat (10) tick();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL reset_pre_busy got=%b exp=1", busy); end
    #2 areset = 1'b1;
    #1;
    checks++;
    if ({key_ready, busy, num_rounds, err_keylen, dbg_state} !== 9'd0 || rd_key !== 128'h0) begin
      failures++;
      $display("FAIL reset_mid got rdy=%b busy=%b nr=%0d st=%0d exp 0", key_ready, busy, num_rounds, dbg_state);
    end
    #1 areset = 1'b0;
    drive_read(4'd0, 1'b0, 128'h0);
    tick();
    tick();
    exp_v = exp_q.pop_front();
    checks++;
    if (rd_key !== exp_v || key_ready !== 1'b0) begin
      failures++; $display("FAIL reset_after got rd=%h rdy=%b exp rd=0 rdy=0", rd_key, key_ready);
    end
  endtask

  initial begin
    test_reset();
    test_aes128();
    test_aes192();
    test_aes256();
    test_abort();
    test_illegal();
    test_small();
    test_same_edge();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
